// File: rtl/hier_child_sequencer.sv
// Hierarchy-node controller: launches NUM_CHILD children sequentially or in parallel,
// supervises completion with a per-wait timeout and reports done/count/error upward.
module hier_child_sequencer #(
  parameter int NUM_CHILD = 5,
  parameter int TIMEOUT   = 255,
  parameter int IDX_W     = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1,
  parameter int TO_W      = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic [NUM_CHILD-1:0] child_en,
  output logic [NUM_CHILD-1:0] child_start,
  input  logic [NUM_CHILD-1:0] child_done,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [IDX_W-1:0]     err_idx,
  output logic [IDX_W:0]       done_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_CHILD-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = NUM_CHILD - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [IDX_W:0] popcount(input logic [NUM_CHILD-1:0] v);
    logic [IDX_W:0] cnt;
    cnt = {(IDX_W+1){1'b0}};
    for (int i = 0; i < NUM_CHILD; i++) begin
      cnt = cnt + {{IDX_W{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  function automatic logic [NUM_CHILD-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NUM_CHILD'(1'b1) << idx;
  endfunction

  state_t                state_r;
  logic                  mode_r;
  logic [NUM_CHILD-1:0]  pend_r;
  logic [IDX_W-1:0]      cur_r;
  logic [TO_W-1:0]       to_cnt_r;
  logic [NUM_CHILD-1:0]  child_start_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  err_r;
  logic [IDX_W-1:0]      err_idx_r;
  logic [IDX_W:0]        done_cnt_r;

  logic [NUM_CHILD-1:0]  hit_mask_s;
  logic [NUM_CHILD-1:0]  pend_next_s;
  logic [IDX_W:0]        cnt_next_s;
  logic                  complete_s;
  logic                  timeout_s;

  // WAIT-phase completion decode: sequential mode only listens to the current child
  always_comb begin
    hit_mask_s  = {NUM_CHILD{1'b0}};
    complete_s  = 1'b0;
    if (mode_r) begin
      hit_mask_s = child_done & pend_r;
    end else begin
      hit_mask_s = child_done & pend_r & onehot(cur_r);
    end
    pend_next_s = pend_r & ~hit_mask_s;
    cnt_next_s  = done_cnt_r + popcount(hit_mask_s);
    if (mode_r) begin
      complete_s = (pend_next_s == {NUM_CHILD{1'b0}});
    end else begin
      complete_s = (hit_mask_s != {NUM_CHILD{1'b0}});
    end
    timeout_s = (to_cnt_r == TO_W'(TIMEOUT - 1));
  end

  // Run-control FSM with all outputs held in registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      mode_r        <= 1'b0;
      pend_r        <= {NUM_CHILD{1'b0}};
      cur_r         <= {IDX_W{1'b0}};
      to_cnt_r      <= {TO_W{1'b0}};
      child_start_r <= {NUM_CHILD{1'b0}};
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      err_idx_r     <= {IDX_W{1'b0}};
      done_cnt_r    <= {(IDX_W+1){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r        <= 1'b0;
          child_start_r <= {NUM_CHILD{1'b0}};
          if (start) begin
            mode_r     <= mode;
            pend_r     <= child_en;
            cur_r      <= lowest_idx(child_en);
            err_r      <= 1'b0;
            err_idx_r  <= {IDX_W{1'b0}};
            done_cnt_r <= {(IDX_W+1){1'b0}};
            busy_r     <= 1'b1;
            if (child_en == {NUM_CHILD{1'b0}}) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r       <= ST_LAUNCH;
              child_start_r <= mode ? child_en : onehot(lowest_idx(child_en));
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_LAUNCH: begin
          child_start_r <= {NUM_CHILD{1'b0}};
          to_cnt_r      <= {TO_W{1'b0}};
          state_r       <= ST_WAIT;
        end
        ST_WAIT: begin
          pend_r     <= pend_next_s;
          done_cnt_r <= cnt_next_s;
          if (complete_s) begin
            // a completion on the last allowed cycle beats the timeout
            if (pend_next_s == {NUM_CHILD{1'b0}}) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              cur_r         <= lowest_idx(pend_next_s);
              child_start_r <= onehot(lowest_idx(pend_next_s));
              state_r       <= ST_LAUNCH;
            end
          end else if (timeout_s) begin
            err_r     <= 1'b1;
            err_idx_r <= mode_r ? lowest_idx(pend_next_s) : cur_r;
            state_r   <= ST_DONE;
            done_r    <= 1'b1;
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1'b1);
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r       <= ST_IDLE;
          child_start_r <= {NUM_CHILD{1'b0}};
          busy_r        <= 1'b0;
          done_r        <= 1'b0;
        end
      endcase
    end
  end

  assign child_start = child_start_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign err         = err_r;
  assign err_idx     = err_idx_r;
  assign done_cnt    = done_cnt_r;

endmodule

// File: tb/tb_hier_child_sequencer.sv
// Scoreboard bench for hier_child_sequencer: a run-level reference model predicts strobes
// and the end-of-run report; a monitor pops and compares whenever the DUT emits them.
module tb_hier_child_sequencer;

  localparam int NC = 5;
  localparam int TO = 8;
  localparam int IW = 3;

  typedef struct { int cyc; logic [NC-1:0] vec; } cs_t;
  typedef struct { int cyc; int cnt; int err; int idx; } dn_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [NC-1:0] child_en = '0;
  logic [NC-1:0] child_done = '0;
  logic [NC-1:0] child_start;
  logic          busy, done, err;
  logic [IW-1:0] err_idx;
  logic [IW:0]   done_cnt;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int delay[NC];
  int due[NC];
  cs_t cs_q[$];
  dn_t dn_q[$];

  hier_child_sequencer #(.NUM_CHILD(NC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .child_en(child_en),
    .child_start(child_start), .child_done(child_done), .busy(busy), .done(done),
    .err(err), .err_idx(err_idx), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Child models: each answers with a one-cycle pulse delay[i] cycles after its strobe; 0 = never
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) due[i] = -1;
      child_done = '0;
    end else begin
      for (int i = 0; i < NC; i++) child_done[i] = (due[i] == cyc);
      for (int i = 0; i < NC; i++)
        if (child_start[i] && delay[i] != 0) due[i] = cyc + delay[i];
    end
  end

  // Monitor: pops the scoreboard whenever the DUT strobes children or signals done
  always @(negedge clk) begin
    cs_t c;
    dn_t d;
    if (rst_n) begin
      if (child_start != '0) begin
        if (cs_q.size() == 0) begin
          total++; bad++;
          $display("FAIL child_start_unexpected: got %b at cycle %0d expected none", child_start, cyc);
        end else begin
          c = cs_q.pop_front();
          check("child_start_vec", int'(child_start), int'(c.vec));
          check("child_start_cyc", cyc, c.cyc);
        end
      end
      if (done) begin
        if (dn_q.size() == 0) begin
          total++; bad++;
          $display("FAIL done_unexpected: got done at cycle %0d expected none", cyc);
        end else begin
          d = dn_q.pop_front();
          check("done_cyc", cyc, d.cyc);
          check("done_cnt", int'(done_cnt), d.cnt);
          check("err", int'(err), d.err);
          check("err_idx", int'(err_idx), d.idx);
        end
      end
    end
  end

  // Run-level reference: walks the enabled children in order and accumulates time
  task automatic predict(input int n, input bit m, input logic [NC-1:0] en, output dn_t e);
    int l;
    int maxd;
    cs_t c;
    e.cnt = 0; e.err = 0; e.idx = 0; e.cyc = n + 1;
    if (en != '0) begin
      if (m) begin
        c.cyc = n + 1; c.vec = en;
        cs_q.push_back(c);
        maxd = 0;
        for (int i = 0; i < NC; i++) begin
          if (en[i]) begin
            if (delay[i] >= 1 && delay[i] <= TO) begin
              e.cnt++;
              if (delay[i] > maxd) maxd = delay[i];
            end else if (e.err == 0) begin
              e.err = 1; e.idx = i;
            end
          end
        end
        e.cyc = (e.err != 0) ? n + TO + 2 : n + 2 + maxd;
      end else begin
        l = n + 1;
        for (int i = 0; i < NC; i++) begin
          if (en[i] && e.err == 0) begin
            c.cyc = l; c.vec = '0; c.vec[i] = 1'b1;
            cs_q.push_back(c);
            if (delay[i] >= 1 && delay[i] <= TO) begin
              e.cnt++;
              l = l + delay[i] + 1;
            end else begin
              e.err = 1; e.idx = i; e.cyc = l + TO + 1;
            end
          end
        end
        if (e.err == 0) e.cyc = l;
      end
    end
  endtask

  task automatic set_delays(input int d0, input int d1, input int d2, input int d3, input int d4);
    delay[0] = d0; delay[1] = d1; delay[2] = d2; delay[3] = d3; delay[4] = d4;
  endtask

  // One run: issue start, push the prediction, optionally hammer start while busy
  task automatic run(input bit m, input logic [NC-1:0] en, input bit noisy);
    int n;
    dn_t e;
    mode = m; child_en = en; start = 1'b1;
    n = cyc;
    predict(n, m, en, e);
    dn_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    while (cyc <= e.cyc) begin
      check("busy_run", int'(busy), 1);
      if (noisy && $urandom_range(0, 2) == 0) begin
        start = 1'b1; mode = 1'($urandom); child_en = NC'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_idle", int'(busy), 0);
    check("err_sticky", int'(err), e.err);
    check("done_cnt_hold", int'(done_cnt), e.cnt);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [NC-1:0] en;
    int r;
    for (int i = 0; i < NC; i++) begin delay[i] = 0; due[i] = -1; end
    repeat (3) @(negedge clk);
    check("rst_child_start", int'(child_start), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_err_idx", int'(err_idx), 0);
    check("rst_done_cnt", int'(done_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk);

    set_delays(1, 1, 1, 1, 1); run(1'b0, 5'b11111, 1'b0);
    set_delays(0, 2, 5, 0, 3); run(1'b1, 5'b10110, 1'b0);
    set_delays(1, 1, 1, 1, 1); run(1'b0, 5'b01001, 1'b0);
    set_delays(1, 1, 0, 1, 1); run(1'b0, 5'b11111, 1'b0);
    set_delays(1, 1, 1, 1, 1); run(1'b0, 5'b00001, 1'b0);
    run(1'b0, 5'b00000, 1'b0);
    run(1'b1, 5'b00000, 1'b0);
    set_delays(2, 3, 1, 2, 1); run(1'b0, 5'b00110, 1'b1);
    set_delays(8, 8, 1, 1, 1); run(1'b0, 5'b00010, 1'b0);
    run(1'b1, 5'b00011, 1'b0);
    set_delays(1, 0, 2, 0, 1); run(1'b1, 5'b11111, 1'b0);

    // Reset in the middle of a parallel WAIT
    set_delays(0, 0, 0, 0, 0);
    begin
      cs_t c;
      c.cyc = cyc + 1; c.vec = 5'b11111;
      cs_q.push_back(c);
    end
    mode = 1'b1; child_en = 5'b11111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_child_start", int'(child_start), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_done_cnt", int'(done_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_delays(1, 2, 1, 1, 3); run(1'b0, 5'b10101, 1'b0);

    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 7);
      if (r == 0) en = '0;
      else if (r == 1) en = '1;
      else en = NC'($urandom);
      for (int i = 0; i < NC; i++) begin
        r = $urandom_range(0, 15);
        if (r == 0) delay[i] = 0;
        else if (r == 1) delay[i] = TO;
        else delay[i] = $urandom_range(1, 3);
      end
      run(1'($urandom), en, 1'($urandom));
    end

    repeat (3) @(negedge clk);
    check("cs_q_empty", cs_q.size(), 0);
    check("dn_q_empty", dn_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hier_child_sequencer.md
# hier_child_sequencer

Parametrised hierarchy-node controller that launches and supervises `NUM_CHILD` child sub-blocks beneath a root node. It runs children one at a time or all at once, and skips masked children. It collects completion, enforces a per-wait timeout, and reports one `done` pulse, a completion count and error status to the parent. It is the next generation of the fixed five-child structural root node: the child count becomes a parameter, and the node gains launch/complete sequencing.

## Interface
- `NUM_CHILD`, 5, number of child channels (1..32).
- `TIMEOUT`, 255, maximum WAIT cycles allowed per wait phase (≥1).
- `IDX_W`, $clog2(NUM_CHILD) (min 1), child index width. Derived; do not override.
- `TO_W`, $clog2(TIMEOUT+1), timeout counter width. Derived; do not override.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  run request; accepted only in IDLE.
- `mode`  in  1  0 = sequential, 1 = parallel; sampled with `start`.
- `child_en`  in  NUM_CHILD  per-child enable mask; sampled with `start`.
- `child_start`  out  NUM_CHILD  launch strobe to each child.
- `child_done`  in  NUM_CHILD  completion from each child, level or pulse.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle end-of-run pulse.
- `err`  out  1  timeout flag; sticky until the next accepted `start`.
- `err_idx`  out  IDX_W  lowest child index still outstanding at timeout.
- `done_cnt`  out  IDX_W+1  number of children completed in this run; valid from `done` until the next accepted `start`.

## Operation
- States: IDLE, LAUNCH, WAIT, DONE.
- **IDLE**
  - On `start`, latch `mode` and `child_en` into `pend` (pending mask).
  - Clear `err`, `err_idx` and `done_cnt`.
  - If `child_en` is 0, go to DONE. Otherwise go to LAUNCH.
  - In sequential mode, also latch `cur` = lowest set bit of `child_en`.
- **LAUNCH**, lasts exactly 1 cycle.
  - Sequential: `child_start` is one-hot at `cur`.
  - Parallel: `child_start` = `pend`.
  - Go to WAIT. Clear the timeout counter.
- **WAIT**: `child_done` is sampled only in this state. It is ignored in IDLE, LAUNCH and DONE.
  - Sequential:
    - On `child_done[cur]`: clear `pend[cur]` and increment `done_cnt`.
    - If other `pend` bits remain, set `cur` to the next higher set bit and go to LAUNCH. Otherwise go to DONE.
    - `done` from other children is ignored.
  - Parallel:
    - Each cycle, clear `pend` bits for every asserted `child_done`. Add their popcount (masked by `pend`) to `done_cnt`.
    - When `pend` becomes 0, go to DONE.
    - A child counts at most once.
  - Timeout: the counter increments each WAIT cycle. If the counter = `TIMEOUT-1` and the completion condition is not met that cycle:
    - set `err`=1;
    - set `err_idx` = lowest set bit of `pend` (sequential: `cur`);
    - go to DONE.
  - A completion arriving on the timeout cycle wins; no error is raised.
- **DONE**, lasts 1 cycle. `done`=1, then go to IDLE.
- `start` while `busy` is ignored and does not queue.
- Reset mid-run: all state returns to IDLE immediately, asynchronously. All outputs read 0. No partial `done` is produced.

## Timing
- Reset values: `child_start`=0, `busy`=0, `done`=0, `err`=0, `err_idx`=0, `done_cnt`=0, state IDLE.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.
- `start` at cycle n gives LAUNCH at n+1 and the first WAIT at n+2.
- Minimum cost per sequential child is 2 cycles (LAUNCH + 1 WAIT).
- Sequential run with k enabled children, each responding on its first WAIT cycle: `done` at n+2k+1.
- Parallel run: `done` comes 1 cycle after the WAIT cycle in which the last pending child completes.
- Empty mask: `done` at n+1, `done_cnt`=0, `busy` high for 1 cycle only.
- Maximum WAIT length is `TIMEOUT` cycles per phase. In sequential mode this is per child.

## Test plan
- **Sequential, all enabled:** `NUM_CHILD`=5, `mode`=0, `child_en`=5'b11111, each child raises done 1 cycle after its `child_start`, `start` at cycle 0 -> `child_start` one-hot 1,2,4,8,16 at cycles 1,3,5,7,9; `done` at cycle 11; `done_cnt`=5; `err`=0.
- **Parallel with skew:** `mode`=1, `child_en`=5'b10110, done from children 1/2/4 at cycles 3/6/4 -> `child_start`=5'b10110 at cycle 1 only; `done` at cycle 7; `done_cnt`=3.
- **Masked sequential:** `child_en`=5'b01001 -> only children 0 and 3 are strobed; `done_cnt`=2; children 1, 2 and 4 never see `child_start`.
- **Timeout:** `TIMEOUT`=8, sequential, child 2 never responds -> 8 WAIT cycles on child 2, then `done`; `err`=1, `err_idx`=2, `done_cnt`=2. The next `start` clears `err`.
- **Boundary:** `child_en`=0 -> `done` the cycle after `start`, `done_cnt`=0. `start` re-asserted while busy -> ignored, one `done` only. A completion on the final timeout cycle -> `err`=0.
- **Reset mid-run:** `rst_n` low during a parallel WAIT -> all outputs 0 immediately. After release, a fresh `start` runs normally.
